video_timing_gen: RTL



---
 rtl/video_timing_gen_pkg.sv | 34 +++
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_gen_pix_ce_div.sv | 35 +++
 rtl/video_timing_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing types, standard modes and total-length helpers
// for the display path.
package video_timing_pkg;

    typedef struct packed {
        int unsigned h_visible;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_visible;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } timing_t;

    localparam timing_t MODE_640x480_60 = '{
        h_visible: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_visible: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    localparam timing_t MODE_800x600_60 = '{
        h_visible: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_visible: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    function automatic int unsigned h_total(input timing_t t);
        return t.h_visible + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int unsigned v_total(input timing_t t);
        return t.v_visible + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle driven by the generator towards renderer and output stage.
interface video_timing_gen_if #(
    parameter int unsigned CW = 10
) ();

    logic          pix_ce;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_ce, x, y, hsync, vsync, video_on, line_start, frame_start
    );

    modport slave (
        input pix_ce, x, y, hsync, vsync, video_on, line_start, frame_start
    );

endinterface

// File: rtl/video_timing_gen_pix_ce_div.sv
// Pixel clock-enable divider: one pix_ce per CLK_DIV enabled system clocks.
module pix_ce_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic pix_ce
);

    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = div_q + DW'(1);
        if (!en || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // With CLK_DIV=1 this is constantly high; the generator qualifies it with en.
    assign pix_ce = (div_q == DIV_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel position, syncs, blanking and
// line/frame strobes, advanced by an internal pixel clock-enable.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CW         = 10,
    parameter int unsigned H_VISIBLE  = MODE_640x480_60.h_visible,
    parameter int unsigned H_FP       = MODE_640x480_60.h_fp,
    parameter int unsigned H_SYNC     = MODE_640x480_60.h_sync,
    parameter int unsigned H_BP       = MODE_640x480_60.h_bp,
    parameter int unsigned V_VISIBLE  = MODE_640x480_60.v_visible,
    parameter int unsigned V_FP       = MODE_640x480_60.v_fp,
    parameter int unsigned V_SYNC     = MODE_640x480_60.v_sync,
    parameter int unsigned V_BP       = MODE_640x480_60.v_bp,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    video_timing_gen_if.master vid
);

    localparam timing_t TIMING = '{
        h_visible: H_VISIBLE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_visible: V_VISIBLE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };
    localparam int unsigned      H_TOTAL   = h_total(TIMING);
    localparam int unsigned      V_TOTAL   = v_total(TIMING);
    localparam longint unsigned  CNT_RANGE = 64'(1) << CW;

    if ((64'(H_TOTAL) > CNT_RANGE) || (64'(V_TOTAL) > CNT_RANGE)) begin : g_bad_range
        $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CW");
    end
    if ((CLK_DIV == 0) || (H_VISIBLE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_VISIBLE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_segment
        $error("video_timing_gen: CLK_DIV and all segment lengths must be non-zero");
    end

    localparam logic [CW-1:0] H_VIS_END = CW'(H_VISIBLE);
    localparam logic [CW-1:0] HS_START  = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_VIS_END = CW'(V_VISIBLE);
    localparam logic [CW-1:0] VS_START  = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);

    logic          pix_ce;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

    pix_ce_div #(.CLK_DIV(CLK_DIV)) u_pix_ce_div (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .pix_ce (pix_ce)
    );

    // Outputs present the decode of (hc,vc) on each pixel edge, then the counter advances.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (!en) begin
            hc_d       = '0;
            vc_d       = '0;
            x_d        = '0;
            y_d        = '0;
            hsync_d    = ~H_SYNC_POL;
            vsync_d    = ~V_SYNC_POL;
            video_on_d = 1'b0;
        end else if (pix_ce) begin
            x_d           = hc_q;
            y_d           = vc_q;
            hsync_d       = ((hc_q >= HS_START) && (hc_q < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d       = ((vc_q >= VS_START) && (vc_q < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
            video_on_d    = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
            line_start_d  = (hc_q == '0);
            frame_start_d = (hc_q == '0) && (vc_q == '0);
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
            end else begin
                hc_d = hc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.pix_ce      = pix_ce;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.video_on    = video_on_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule
